// File: rtl/song_player_if.sv
// Signal bundle between the song player and its surroundings: control inputs
// from the song-select/pause controller, the note ROM bus, and the tone
// generator outputs.
interface song_player_if #(
   parameter int ADDR_W = 8
);
   logic [2:0]        mode;
   logic              pause;
   logic [1:0]        song_num;
   logic              learn_hit;
   logic [ADDR_W-1:0] rom_addr;
   logic [9:0]        rom_data;
   logic [3:0]        pitch;
   logic [1:0]        octave;
   logic              note_on;
   logic              song_done;

   // Environment side: drives controls and ROM data, observes the player.
   modport master (
      output mode, pause, song_num, learn_hit, rom_data,
      input  rom_addr, pitch, octave, note_on, song_done
   );

   // Player side.
   modport slave (
      input  mode, pause, song_num, learn_hit, rom_data,
      output rom_addr, pitch, octave, note_on, song_done
   );
endinterface

// File: rtl/song_player.sv
// Song player: walks a song's note table in an external synchronous ROM and
// drives pitch/octave/note_on to the tone generator. Auto mode advances on a
// timed beat; learning mode holds each note until the player hits the key.
module song_player #(
   parameter int ADDR_W     = 8,
   parameter int UNIT_TICKS = 12_500_000,
   parameter int GAP_TICKS  = 1_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   song_player_if.slave bus
);
   localparam int OFF_W  = ADDR_W - 2;
   localparam int TICK_W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
   localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE
   } state_t;

   state_t              state_reg, state_next;
   logic [OFF_W-1:0]    offset_reg, offset_next;
   logic [ADDR_W-1:0]   rom_addr_reg, rom_addr_next;
   logic [3:0]          pitch_reg, pitch_next;
   logic [1:0]          octave_reg, octave_next;
   logic                note_on_reg, note_on_next;
   logic                song_done_reg, song_done_next;
   logic [3:0]          dur_reg, dur_next;
   logic [3:0]          unit_reg, unit_next;
   logic [TICK_W-1:0]   tick_reg, tick_next;
   logic [GAP_W-1:0]    gap_reg, gap_next;
   logic [1:0]          song_reg;
   logic [2:0]          mode_reg;

   logic active, auto_mode, mode_reg_active, restart, frozen;
   logic [OFF_W-1:0] offset_inc;

   assign active          = (bus.mode == 3'b011) || (bus.mode == 3'b111);
   assign auto_mode       = (bus.mode == 3'b011);
   assign mode_reg_active = (mode_reg == 3'b011) || (mode_reg == 3'b111);
   // A new song, or a flip between auto and learning, restarts the table.
   assign restart         = (bus.song_num != song_reg) ||
                            (active && mode_reg_active && (bus.mode != mode_reg));
   assign frozen          = auto_mode && bus.pause &&
                            ((state_reg == S_PLAY) || (state_reg == S_GAP));
   assign offset_inc      = offset_reg + 1'b1;

   // Next-state and output decode; inactive > restart > pause > hit/timer.
   always_comb begin
      state_next     = state_reg;
      offset_next    = offset_reg;
      rom_addr_next  = rom_addr_reg;
      pitch_next     = pitch_reg;
      octave_next    = octave_reg;
      note_on_next   = note_on_reg;
      song_done_next = song_done_reg;
      dur_next       = dur_reg;
      unit_next      = unit_reg;
      tick_next      = tick_reg;
      gap_next       = gap_reg;

      if (!active) begin
         state_next     = S_IDLE;
         offset_next    = '0;
         rom_addr_next  = '0;
         pitch_next     = '0;
         octave_next    = '0;
         note_on_next   = 1'b0;
         song_done_next = 1'b0;
         unit_next      = '0;
         tick_next      = '0;
         gap_next       = '0;
      end else if ((state_reg == S_IDLE) || restart) begin
         state_next     = S_FETCH;
         offset_next    = '0;
         rom_addr_next  = {bus.song_num, {OFF_W{1'b0}}};
         note_on_next   = 1'b0;
         song_done_next = 1'b0;
         unit_next      = '0;
         tick_next      = '0;
         gap_next       = '0;
      end else begin
         case (state_reg)
            // Address was presented on entry; ROM answers during LOAD.
            S_FETCH: state_next = S_LOAD;
            S_LOAD: begin
               if (bus.rom_data[9]) begin
                  state_next     = S_DONE;
                  song_done_next = 1'b1;
                  pitch_next     = '0;
                  note_on_next   = 1'b0;
               end else begin
                  state_next   = S_PLAY;
                  octave_next  = bus.rom_data[8:7];
                  pitch_next   = bus.rom_data[6:3];
                  dur_next     = {1'b0, bus.rom_data[2:0]} + 4'd1;
                  note_on_next = (bus.rom_data[6:3] != 4'd0);
                  unit_next    = '0;
                  tick_next    = '0;
               end
            end
            S_PLAY: begin
               if (frozen) begin
                  note_on_next = 1'b0;
               end else if (!auto_mode) begin
                  if ((pitch_reg == 4'd0) || bus.learn_hit) begin
                     state_next   = S_GAP;
                     note_on_next = 1'b0;
                     gap_next     = '0;
                  end else begin
                     note_on_next = 1'b1;
                  end
               end else begin
                  note_on_next = (pitch_reg != 4'd0);
                  if (tick_reg == TICK_W'(UNIT_TICKS - 1)) begin
                     tick_next = '0;
                     if (4'(unit_reg + 4'd1) == dur_reg) begin
                        state_next   = S_GAP;
                        note_on_next = 1'b0;
                        gap_next     = '0;
                     end else begin
                        unit_next = unit_reg + 4'd1;
                     end
                  end else begin
                     tick_next = tick_reg + 1'b1;
                  end
               end
            end
            S_GAP: begin
               note_on_next = 1'b0;
               if (!frozen) begin
                  if (gap_reg == GAP_W'(GAP_TICKS - 1)) begin
                     gap_next      = '0;
                     offset_next   = offset_inc;
                     rom_addr_next = {bus.song_num, offset_inc};
                     state_next    = S_FETCH;
                  end else begin
                     gap_next = gap_reg + 1'b1;
                  end
               end
            end
            S_DONE: begin
               song_done_next = 1'b1;
               note_on_next   = 1'b0;
               pitch_next     = '0;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         offset_reg    <= '0;
         rom_addr_reg  <= '0;
         pitch_reg     <= '0;
         octave_reg    <= '0;
         note_on_reg   <= 1'b0;
         song_done_reg <= 1'b0;
         dur_reg       <= '0;
         unit_reg      <= '0;
         tick_reg      <= '0;
         gap_reg       <= '0;
         song_reg      <= '0;
         mode_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         offset_reg    <= offset_next;
         rom_addr_reg  <= rom_addr_next;
         pitch_reg     <= pitch_next;
         octave_reg    <= octave_next;
         note_on_reg   <= note_on_next;
         song_done_reg <= song_done_next;
         dur_reg       <= dur_next;
         unit_reg      <= unit_next;
         tick_reg      <= tick_next;
         gap_reg       <= gap_next;
         song_reg      <= bus.song_num;
         mode_reg      <= bus.mode;
      end
   end

   assign bus.rom_addr  = rom_addr_reg;
   assign bus.pitch     = pitch_reg;
   assign bus.octave    = octave_reg;
   assign bus.note_on   = note_on_reg;
   assign bus.song_done = song_done_reg;
endmodule

// File: tb/tb_song_player.sv
// Bench for song_player: the stimulus pushes the expected sequence of output
// runs (output tuple + length in cycles) into a queue; a monitor compresses
// the observed outputs into runs and compares each completed run.
module tb_song_player;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   song_player_if #(.ADDR_W(6)) sp_if ();

   song_player #(.ADDR_W(6), .UNIT_TICKS(4), .GAP_TICKS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sp_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] addr;
      logic [3:0] pitch;
      logic [1:0] oct;
      logic       on;
      logic       done;
   } obs_t;

   typedef struct packed {
      obs_t        obs;
      logic [15:0] len;   // 0 = length not checked
   } exp_t;

   logic [9:0] rom [64];
   exp_t       exp_q [$];
   obs_t       run_obs;
   int         run_len = 0;
   int         run_idx = 0;
   bit         mon_en  = 1'b0;
   int         checks  = 0;
   int         errors  = 0;

   // Synchronous ROM: data valid one cycle after the address.
   always @(posedge clk) sp_if.rom_data <= rom[sp_if.rom_addr];

   function automatic logic [9:0] ent(input logic e, input logic [1:0] o,
                                      input logic [3:0] p, input logic [2:0] d);
      return {e, o, p, d};
   endfunction

   task automatic push(input logic [5:0] a, input logic [3:0] p, input logic [1:0] o,
                       input logic on, input logic dn, input int len);
      exp_t e;
      e.obs  = '{addr: a, pitch: p, oct: o, on: on, done: dn};
      e.len  = 16'(len);
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end else begin
         $display("check %s: %0d ok", name, act);
      end
   endtask

   task automatic close_run();
      exp_t e;
      checks++;
      run_idx++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL run%0d unexpected: addr=%h pitch=%0d oct=%0d on=%0d done=%0d len=%0d",
                  run_idx, run_obs.addr, run_obs.pitch, run_obs.oct, run_obs.on,
                  run_obs.done, run_len);
      end else begin
         e = exp_q.pop_front();
         if (e.obs != run_obs || (e.len != 0 && int'(e.len) != run_len)) begin
            errors++;
            $display("FAIL run%0d: got addr=%h pitch=%0d oct=%0d on=%0d done=%0d len=%0d, required addr=%h pitch=%0d oct=%0d on=%0d done=%0d len=%0d",
                     run_idx, run_obs.addr, run_obs.pitch, run_obs.oct, run_obs.on,
                     run_obs.done, run_len, e.obs.addr, e.obs.pitch, e.obs.oct,
                     e.obs.on, e.obs.done, e.len);
         end else begin
            $display("run%0d: addr=%h pitch=%0d oct=%0d on=%0d done=%0d len=%0d ok",
                     run_idx, run_obs.addr, run_obs.pitch, run_obs.oct, run_obs.on,
                     run_obs.done, run_len);
         end
      end
   endtask

   // Monitor: sample on the falling edge, close a run whenever outputs change.
   initial begin
      obs_t cur;
      forever begin
         @(negedge clk);
         cur = '{addr: sp_if.rom_addr, pitch: sp_if.pitch, oct: sp_if.octave,
                 on: sp_if.note_on, done: sp_if.song_done};
         if (mon_en) begin
            if (run_len == 0) begin
               run_obs = cur;
               run_len = 1;
            end else if (cur == run_obs) begin
               run_len++;
            end else begin
               close_run();
               run_obs = cur;
               run_len = 1;
            end
         end else if (run_len != 0) begin
            close_run();
            run_len = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic go_idle();
      sp_if.mode = 3'b000;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic start_mon();
      mon_en = 1'b1;
   endtask

   task automatic stop_mon();
      mon_en = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      sp_if.mode      = 3'b000;
      sp_if.pause     = 1'b0;
      sp_if.song_num  = 2'd0;
      sp_if.learn_hit = 1'b0;
      for (int i = 0; i < 64; i++) rom[i] = ent(1'b1, 2'd0, 4'd0, 3'd0);
      // Song 0: 16 notes, no end marker.
      for (int i = 0; i < 16; i++) rom[i] = ent(1'b0, 2'(i / 4), 4'((i % 15) + 1), 3'd0);
      // Song 1: one long note.
      rom[16] = ent(1'b0, 2'd2, 4'd9, 3'd3);
      // Song 2: one short note.
      rom[32] = ent(1'b0, 2'd1, 4'd5, 3'd1);
      // Song 3: note, rest, end.
      rom[48] = ent(1'b0, 2'd1, 4'd7, 3'd0);
      rom[49] = ent(1'b0, 2'd0, 4'd0, 3'd2);

      // Reset state.
      #1;
      check("reset_note_on", int'(sp_if.note_on), 0);
      check("reset_rom_addr", int'(sp_if.rom_addr), 0);
      check("reset_song_done", int'(sp_if.song_done), 0);
      check("reset_pitch", int'(sp_if.pitch), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Auto mode, song 2.
      go_idle();
      sp_if.song_num = 2'd2;
      push(6'h00, 0, 0, 0, 0, 0);
      push(6'h20, 0, 0, 0, 0, 2);
      push(6'h20, 5, 1, 1, 0, 8);
      push(6'h20, 5, 1, 0, 0, 2);
      push(6'h21, 5, 1, 0, 0, 2);
      push(6'h21, 0, 1, 0, 1, 0);
      start_mon();
      @(posedge clk); #1;
      sp_if.mode = 3'b011;
      repeat (20) @(posedge clk);
      #1 stop_mon();

      // Pause in auto mode, song 1 (4 units = 16 cycles).
      go_idle();
      sp_if.song_num = 2'd1;
      push(6'h00, 0, 0, 0, 0, 0);
      push(6'h10, 0, 0, 0, 0, 2);
      push(6'h10, 9, 2, 1, 0, 5);
      push(6'h10, 9, 2, 0, 0, 10);
      push(6'h10, 9, 2, 1, 0, 11);
      push(6'h10, 9, 2, 0, 0, 2);
      push(6'h11, 9, 2, 0, 0, 2);
      push(6'h11, 0, 2, 0, 1, 0);
      start_mon();
      @(posedge clk); #1;
      sp_if.mode = 3'b011;
      repeat (7) @(posedge clk);
      #1 sp_if.pause = 1'b1;
      repeat (10) @(posedge clk);
      #1 sp_if.pause = 1'b0;
      repeat (20) @(posedge clk);
      #1 stop_mon();

      // Learning mode, song 3, pause held high throughout.
      go_idle();
      sp_if.song_num = 2'd3;
      sp_if.pause    = 1'b1;
      push(6'h00, 0, 0, 0, 0, 0);
      push(6'h30, 0, 0, 0, 0, 2);
      push(6'h30, 7, 1, 1, 0, 100);
      push(6'h30, 7, 1, 0, 0, 2);
      push(6'h31, 7, 1, 0, 0, 2);
      push(6'h31, 0, 0, 0, 0, 3);
      push(6'h32, 0, 0, 0, 0, 2);
      push(6'h32, 0, 0, 0, 1, 0);
      start_mon();
      @(posedge clk); #1;
      sp_if.mode = 3'b111;
      repeat (102) @(posedge clk);
      #1 sp_if.learn_hit = 1'b1;
      @(posedge clk);
      #1 sp_if.learn_hit = 1'b0;
      repeat (12) @(posedge clk);
      #1 stop_mon();
      sp_if.pause = 1'b0;

      // Song change mid-note, then mode drop mid-gap.
      go_idle();
      sp_if.song_num = 2'd1;
      push(6'h00, 0, 0, 0, 0, 0);
      push(6'h10, 0, 0, 0, 0, 2);
      push(6'h10, 9, 2, 1, 0, 6);
      push(6'h30, 9, 2, 0, 0, 2);
      push(6'h30, 7, 1, 1, 0, 4);
      push(6'h30, 7, 1, 0, 0, 1);
      push(6'h00, 0, 0, 0, 0, 0);
      start_mon();
      @(posedge clk); #1;
      sp_if.mode = 3'b011;
      repeat (8) @(posedge clk);
      #1 sp_if.song_num = 2'd3;
      repeat (7) @(posedge clk);
      #1 sp_if.mode = 3'b001;
      repeat (4) @(posedge clk);
      #1 stop_mon();

      // Offset wrap on song 0: 16 entries then back to 6'h00.
      go_idle();
      sp_if.song_num = 2'd0;
      push(6'h00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) push(6'(i), 4'(((i - 1) % 15) + 1), 2'((i - 1) / 4), 0, 0, 2);
         push(6'(i), 4'((i % 15) + 1), 2'(i / 4), 1, 0, 4);
         push(6'(i), 4'((i % 15) + 1), 2'(i / 4), 0, 0, 2);
      end
      push(6'h00, 4'd1, 2'd3, 0, 0, 2);
      push(6'h00, 4'd1, 2'd0, 1, 0, 0);
      start_mon();
      @(posedge clk); #1;
      sp_if.mode = 3'b011;
      repeat (133) @(posedge clk);
      #1 stop_mon();

      // Asynchronous reset mid-PLAY, then stay idle.
      go_idle();
      sp_if.song_num = 2'd2;
      sp_if.mode     = 3'b011;
      repeat (4) @(posedge clk);
      check("preplay_note_on", int'(sp_if.note_on), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_note_on", int'(sp_if.note_on), 0);
      check("async_rst_rom_addr", int'(sp_if.rom_addr), 0);
      check("async_rst_song_done", int'(sp_if.song_done), 0);
      check("async_rst_pitch", int'(sp_if.pitch), 0);
      sp_if.mode = 3'b000;
      @(posedge clk);
      #1 rst_n = 1'b1;
      push(6'h00, 0, 0, 0, 0, 0);
      start_mon();
      repeat (6) @(posedge clk);
      #1 stop_mon();

      check("leftover_expectations", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/song_player.md
Name: song_player

Overview:
- Downstream consumer of the song-select/pause controller's `song_num` and `pause` outputs.
- Walks a song's note table in an external synchronous ROM, one note per entry.
- Drives pitch/octave/note_on to the tone generator (buzzer PWM).
- Auto mode (3'b011): notes advance on a timed beat. Learning mode (3'b111): each note is held until the player hits the correct key.

Parameters:
ADDR_W, 8, ROM address width; each song owns one quarter of the ROM (2^(ADDR_W-2) entries).
UNIT_TICKS, 12_500_000, clk cycles per duration unit (1/8 s at 100 MHz).
GAP_TICKS, 1_000_000, silent clk cycles inserted between consecutive notes.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mode  in  3  3'b011 auto, 3'b111 learning, any other value idle
pause  in  1  level; 1 freezes playback (auto mode only)
song_num  in  2  selected song
learn_hit  in  1  single-cycle pulse: player pressed the currently expected key
rom_addr  out  ADDR_W  registered ROM address = {song_num, offset}
rom_data  in  10  {end_flag[9], octave[8:7], pitch[6:3], dur[2:0]}, valid 1 cycle after rom_addr
pitch  out  4  current pitch index; 0 = rest
octave  out  2  current octave
note_on  out  1  1 = tone generator sounds pitch/octave
song_done  out  1  1 while the end marker has been reached

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; rom_addr=0; pitch=0; octave=0; note_on=0; song_done=0; all counters=0.
- Active means mode is 3'b011 or 3'b111.
- States:
  - IDLE: outputs silent. Entered whenever inactive. On becoming active: offset=0, go to FETCH.
  - FETCH (1 cycle): rom_addr={song_num, offset}, go to LOAD.
  - LOAD (1 cycle): capture rom_data.
    - end_flag=1 → DONE.
    - else pitch/octave ← entry, dur_units = dur+1 (1..8), go to PLAY.
    - note_on rises on the cycle after LOAD, i.e. 2 cycles after entering FETCH.
  - PLAY, auto mode:
    - note_on=(pitch!=0).
    - tick counter 0..UNIT_TICKS-1; unit counter increments on tick wrap.
    - After dur_units*UNIT_TICKS cycles → GAP.
  - PLAY, learning mode:
    - pitch!=0: note_on=1, held indefinitely. A learn_hit pulse → GAP next cycle. learn_hit in any other state is ignored.
    - pitch=0 (rest): → GAP immediately, no learn_hit needed.
  - GAP: note_on=0, pitch/octave hold. After GAP_TICKS cycles: offset+1, go to FETCH.
  - DONE: song_done=1, note_on=0, pitch=0. Holds until mode or song_num changes.
- Offset arithmetic: (ADDR_W-2) bits, wraps from all-ones to 0 with no carry into the song bits. A table with no end marker loops.
- Pause (auto mode only):
  - While pause=1 in PLAY or GAP: tick/unit/gap counters freeze, note_on forced 0, pitch/octave hold.
  - On release, resume from the exact frozen count; the remaining duration is preserved.
  - pause is ignored in learning mode and in IDLE/FETCH/LOAD/DONE. FETCH/LOAD complete even if pause=1.
- Restart events, each sampled every cycle:
  - song_num differs from its registered copy, or mode switches between 3'b011 and 3'b111.
  - Response, next cycle: offset=0, counters=0, note_on=0, song_done=0, state=FETCH with the new song_num.
- Priority per cycle: inactive mode > restart event > pause > learn_hit / timer expiry.
- Mode becoming inactive: IDLE on the next clock edge, outputs cleared, regardless of state.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
Use ADDR_W=6, UNIT_TICKS=4, GAP_TICKS=2 unless noted.
1. Reset: assert rst_n=0 mid-PLAY with no clock edge → note_on=0, rom_addr=0, song_done=0 immediately; after release with mode=3'b000, stays IDLE.
2. Auto mode, song 2: entry 0={0,2'd1,4'd5,3'd1}, entry 1=end. After mode→3'b011: rom_addr=6'h20, note_on=1 with pitch=5/octave=1 for 8 cycles, then 2 silent cycles, rom_addr=6'h21, song_done=1.
3. Pause: dur=3 (16 cycles). Assert pause at cycle 5 of PLAY for 10 cycles → note_on=0, counters frozen; after release note_on=1 for exactly 11 more cycles.
4. Learning mode, pitch=7: note_on held for 100 cycles with no advance; learn_hit pulse → note_on=0 next cycle, next fetch 2 cycles later. Rest entry advances without learn_hit; pause=1 has no effect.
5. song_num 1→3 mid-note → next cycle note_on=0, state FETCH, rom_addr=6'h30. Mode 3'b011→3'b001 mid-GAP → IDLE, all outputs cleared.
6. Wrap: song 0 table with no end marker → after entry 15 rom_addr returns to 6'h00 (never 6'h10), song_done stays 0.
